// File: rtl/barrel_shifter_right_pipelined_if.sv
// Handshake/data bundle for barrel_shifter_right_pipelined.
//   master : producer/consumer side (drives In*, Mode, ShiftIn, OutReady)
//   slave  : the shifter (drives InReady, OutValid, Out)
// Signals:
//   InValid/InReady           input-side handshake
//   In, ShiftAmount, Mode     operand, right shift distance, 00/11 logical,
//                             01 arithmetic, 10 rotate
//   ShiftIn                   fill bit for logical mode
//   OutValid/OutReady         output-side handshake
//   Out                       shifted result
interface barrel_shifter_right_pipelined_if #(
  parameter int WIDTH = 32
);
  localparam int AW = $clog2(WIDTH);

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] In;
  logic [AW-1:0]    ShiftAmount;
  logic [1:0]       Mode;
  logic             ShiftIn;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Out;

  modport master (
    output InValid, In, ShiftAmount, Mode, ShiftIn, OutReady,
    input  InReady, OutValid, Out
  );

  modport slave (
    input  InValid, In, ShiftAmount, Mode, ShiftIn, OutReady,
    output InReady, OutValid, Out
  );
endinterface

// File: rtl/barrel_shifter_right_pipelined.sv
// Pipelined right barrel shifter with valid/ready flow control.
// log2(WIDTH) registered stages; stage k shifts by 2^(S-k) when bit (S-k)
// of the carried ShiftAmount is set. Modes: logical (ShiftIn fill),
// arithmetic (sign fill), rotate; Mode 11 acts as logical.
// Ports:
//   Clock    rising-edge clock
//   Reset_n  asynchronous active-low reset; clears every stage
//   bus      slave modport of barrel_shifter_right_pipelined_if
module barrel_shifter_right_pipelined #(
  parameter int WIDTH = 32
) (
  input  logic                                 Clock,
  input  logic                                 Reset_n,
  barrel_shifter_right_pipelined_if.slave      bus
);
  localparam int S = $clog2(WIDTH);

  // Per-stage registers
  logic [S:1]       v_q;
  logic [WIDTH-1:0] data_q [1:S];
  logic [S-1:0]     amt_q  [1:S];
  logic [1:0]       mode_q [1:S];
  logic             fill_q [1:S];

  // What each stage would load: the previous stage (or the input port)
  logic [S:1]       v_prev;
  logic [WIDTH-1:0] data_prev [1:S];
  logic [S-1:0]     amt_prev  [1:S];
  logic [1:0]       mode_prev [1:S];
  logic             fill_prev [1:S];
  logic [WIDTH-1:0] data_d    [1:S];

  // acc[k]: stage k may load this edge. acc[S+1] is the consumer.
  logic [S+1:1]     acc;
  logic             in_fill;

  // Fill is resolved once at the input so later stages never need the MSB.
  assign in_fill = (bus.Mode == 2'b01) ? bus.In[WIDTH-1] : bus.ShiftIn;

  genvar gi;
  generate
    for (gi = 1; gi <= S; gi++) begin : g_stage
      localparam int D = 1 << (S - gi);
      logic rot;

      if (gi == 1) begin : g_src_in
        assign v_prev[gi]    = bus.InValid;
        assign data_prev[gi] = bus.In;
        assign amt_prev[gi]  = bus.ShiftAmount;
        assign mode_prev[gi] = bus.Mode;
        assign fill_prev[gi] = in_fill;
      end else begin : g_src_stage
        assign v_prev[gi]    = v_q[gi-1];
        assign data_prev[gi] = data_q[gi-1];
        assign amt_prev[gi]  = amt_q[gi-1];
        assign mode_prev[gi] = mode_q[gi-1];
        assign fill_prev[gi] = fill_q[gi-1];
      end

      assign rot = (mode_prev[gi] == 2'b10);

      assign data_d[gi] = !amt_prev[gi][S-gi] ? data_prev[gi] :
                          rot ? {data_prev[gi][D-1:0], data_prev[gi][WIDTH-1:D]} :
                                {{D{fill_prev[gi]}},   data_prev[gi][WIDTH-1:D]};
    end
  endgenerate

  // Ready ripples backwards: an empty stage can always take a new entry,
  // a full one only if its successor is moving this edge.
  always_comb begin
    acc      = '0;
    acc[S+1] = bus.OutReady;
    for (int k = S; k >= 1; k--) begin
      acc[k] = ~v_q[k] | acc[k+1];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      v_q <= '0;
      for (int k = 1; k <= S; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
        fill_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 1; k <= S; k++) begin
        if (acc[k]) begin
          v_q[k] <= v_prev[k];
          // A bubble only clears V; payload fields keep their old contents.
          if (v_prev[k]) begin
            data_q[k] <= data_d[k];
            amt_q[k]  <= amt_prev[k];
            mode_q[k] <= mode_prev[k];
            fill_q[k] <= fill_prev[k];
          end
        end
      end
    end
  end

  assign bus.InReady  = acc[1];
  assign bus.OutValid = v_q[S];
  assign bus.Out      = data_q[S];
endmodule
